// File: rtl/vector_mem_stage_pkg.sv
// Shared types for the vector memory stage: request opcodes, sequencer states
// and small opcode decode helpers.
package vector_mem_pkg;

    typedef enum logic [1:0] {
        OP_SLD = 2'b00,
        OP_SST = 2'b01,
        OP_VLD = 2'b10,
        OP_VST = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    function automatic logic op_is_store(op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_vector(op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/vector_mem_stage_if.sv
// Request/response bus between the execute stage (master) and the
// vector memory stage (slave).
interface vector_mem_stage_if
    import vector_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ADDR_W = 32
);
    logic                    req_valid;
    logic                    req_ready;
    op_e                     req_op;
    logic [ADDR_W-1:0]       req_addr;
    logic [ADDR_W-1:0]       req_stride;
    logic [LANES*DATA_W-1:0] req_wdata;
    logic                    resp_valid;
    logic [LANES*DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_stride, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_stride, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/vector_mem_stage_addr_gen.sv
// Lane address accumulator: loads the base address, then adds the stride once
// per step so lane N sees base + N*stride (wrapping modulo 2^ADDR_W).
module vms_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr
);
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (step) begin
            addr <= addr + stride;
        end
    end
endmodule

// File: rtl/vector_mem_stage.sv
// Memory-stage sequencer: serialises scalar and LANES-wide vector loads/stores
// onto a single-port data memory and provides the ALU writeback mux.
module vector_mem_stage
    import vector_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    vector_mem_stage_if.slave       bus,
    input  logic                    select_alu,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic [LANES*DATA_W-1:0] valu_result,
    output logic [LANES*DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);
    localparam int LANE_W = $clog2(LANES);

    state_e            state;
    op_e               op;
    logic [ADDR_W-1:0] stride;
    logic [DATA_W-1:0] wdata_lanes [LANES];
    logic [DATA_W-1:0] load_buf    [LANES];
    logic [DATA_W-1:0] load_merged [LANES];
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_next;
    logic [LANE_W-1:0] last_lane;
    logic [LANE_W-1:0] cap_lane;
    logic              cap_valid;
    logic              accept;
    logic              is_load;
    logic              step;

    assign bus.req_ready = (state == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_load       = !op_is_store(op);
    assign last_lane     = op_is_vector(op) ? LANE_W'(LANES - 1) : '0;
    assign lane_next     = lane + 1'b1;
    assign step          = (state == ISSUE) && (lane != last_lane);

    assign wb_data = select_alu ? valu_result
                                : {{((LANES - 1) * DATA_W){1'b0}}, alu_result};

    vms_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (step),
        .base   (bus.req_addr),
        .stride (stride),
        .addr   (mem_addr)
    );

    // Read data returns one cycle after issue, so the lane being captured
    // trails the lane being issued by one cycle.
    always_comb begin
        load_merged = load_buf;
        if (cap_valid) begin
            load_merged[cap_lane] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op             <= OP_SLD;
            stride         <= '0;
            lane           <= '0;
            cap_lane       <= '0;
            cap_valid      <= 1'b0;
            mem_we         <= 1'b0;
            mem_wdata      <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            for (int i = 0; i < LANES; i++) begin
                wdata_lanes[i] <= '0;
                load_buf[i]    <= '0;
            end
        end else begin
            bus.resp_valid <= 1'b0;
            cap_valid      <= 1'b0;
            if (cap_valid) begin
                load_buf <= load_merged;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ISSUE;
                        op        <= bus.req_op;
                        stride    <= bus.req_stride;
                        lane      <= '0;
                        mem_we    <= op_is_store(bus.req_op);
                        mem_wdata <= bus.req_wdata[DATA_W-1:0];
                        for (int i = 0; i < LANES; i++) begin
                            wdata_lanes[i] <= bus.req_wdata[i*DATA_W +: DATA_W];
                            load_buf[i]    <= '0;
                        end
                    end
                end
                ISSUE: begin
                    cap_valid <= is_load;
                    cap_lane  <= lane;
                    if (lane == last_lane) begin
                        mem_we <= 1'b0;
                        if (is_load) begin
                            state <= WAIT;
                        end else begin
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                        end
                    end else begin
                        lane      <= lane_next;
                        mem_wdata <= wdata_lanes[lane_next];
                    end
                end
                WAIT: begin
                    state          <= DONE;
                    bus.resp_valid <= 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        bus.resp_rdata[i*DATA_W +: DATA_W] <= load_merged[i];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_mem_stage.sv
// Directed self-checking bench for vector_mem_stage driving a behavioural
// single-port data memory with one-cycle read latency.
`timescale 1ns/1ps
module tb_vector_mem_stage;
    import vector_mem_pkg::*;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int ADDR_W = 32;

    typedef logic [LANES*DATA_W-1:0] vec_w_t;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] stride;
        vec_w_t      wdata;
        int          exp_lat;
        vec_w_t      exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        select_alu;
    logic [31:0] alu_result;
    vec_w_t      valu_result;
    vec_w_t      wb_data;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    vec_w_t      got_rdata;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] mem [1024];
    vec_t        vecs [8];

    vector_mem_stage_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    vector_mem_stage #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .select_alu  (select_alu),
        .alu_result  (alu_result),
        .valu_result (valu_result),
        .wb_data     (wb_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-indexed memory; every address used by the bench maps to a distinct word.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[11:2]];
    end

    task automatic checkOutput(input string name, input vec_w_t actual, input vec_w_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveRequest(input op_e op, input logic [31:0] addr, input logic [31:0] stride,
                                input vec_w_t wdata);
        int n = 0;
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_stride = stride;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checkOutput("accept_timeout", vec_w_t'(0), vec_w_t'(1));
            bus.req_valid = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic collectResponse();
        lat = -1;
        wr_addr.delete();
        wr_data.delete();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (mem_we) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
            if (bus.resp_valid) begin
                lat       = c;
                got_rdata = bus.resp_rdata;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        int          nw;
        logic [31:0] ea;
        logic [31:0] ed;
        driveRequest(v.op, v.addr, v.stride, v.wdata);
        collectResponse();
        checkOutput({tag, "_latency"}, vec_w_t'(lat), vec_w_t'(v.exp_lat));
        checkOutput({tag, "_rdata"}, got_rdata, v.exp_rdata);
        nw = (v.op == OP_SST) ? 1 : (v.op == OP_VST) ? LANES : 0;
        checkOutput({tag, "_nwrites"}, vec_w_t'(wr_addr.size()), vec_w_t'(nw));
        for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
            ea = v.addr + 32'(i) * v.stride;
            ed = v.wdata[i*DATA_W +: DATA_W];
            checkOutput($sformatf("%s_waddr%0d", tag, i), vec_w_t'(wr_addr[i]), vec_w_t'(ea));
            checkOutput($sformatf("%s_wdata%0d", tag, i), vec_w_t'(wr_data[i]), vec_w_t'(ed));
        end
        @(negedge clk);
        checkOutput({tag, "_after_done"}, vec_w_t'({bus.resp_valid, bus.req_ready}), vec_w_t'(2'b01));
    endtask

    initial begin
        int     busy_we;
        int     resp_cyc;
        int     ready_cyc;
        int     cnt_we;
        int     cnt_rv;
        vec_t   rec;
        vec_w_t row3;
        vec_w_t row4;

        bus.req_valid  = 1'b0;
        bus.req_op     = OP_SLD;
        bus.req_addr   = '0;
        bus.req_stride = '0;
        bus.req_wdata  = '0;
        select_alu     = 1'b0;
        alu_result     = '0;
        valu_result    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        row3 = 128'h11110003_11110002_11110001_11110000;
        row4 = 128'h22220003_22220002_22220001_22220000;
        mem[32'h10 >> 2]         = 32'hDEADBEEF;
        mem[32'h200 >> 2]        = 32'h11110000;
        mem[32'h1F8 >> 2]        = 32'h11110001;
        mem[32'h1F0 >> 2]        = 32'h11110002;
        mem[32'h1E8 >> 2]        = 32'h11110003;
        mem[32'hFFC >> 2]        = 32'h22220000;
        mem[0]                   = 32'h22220001;
        mem[1]                   = 32'h22220002;
        mem[2]                   = 32'h22220003;

        vecs[0] = '{OP_SLD, 32'h10,       32'h0,        '0, 3, {96'h0, 32'hDEADBEEF}};
        vecs[1] = '{OP_VST, 32'h100,      32'h4,        128'h00000004_00000003_00000002_00000001,
                    5, {96'h0, 32'hDEADBEEF}};
        vecs[2] = '{OP_VLD, 32'h200,      32'hFFFFFFF8, '0, 6, row3};
        vecs[3] = '{OP_VLD, 32'hFFFFFFFC, 32'h4,        '0, 6, row4};
        vecs[4] = '{OP_SST, 32'h20,       32'h1234,     128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000055, 2, row4};
        vecs[5] = '{OP_VST, 32'h300,      32'h0,        128'h000000D4_000000D3_000000D2_000000D1, 5, row4};
        vecs[6] = '{OP_SLD, 32'h300,      32'h4,        '0, 3, {96'h0, 32'h000000D4}};
        vecs[7] = '{OP_VLD, 32'h100,      32'h4,        '0, 6, 128'h00000004_00000003_00000002_00000001};

        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready",  vec_w_t'(bus.req_ready),  vec_w_t'(0));
        checkOutput("rst_resp_valid", vec_w_t'(bus.resp_valid), vec_w_t'(0));
        checkOutput("rst_resp_rdata", bus.resp_rdata,           vec_w_t'(0));
        checkOutput("rst_mem_we",     vec_w_t'(mem_we),         vec_w_t'(0));
        checkOutput("rst_mem_addr",   vec_w_t'(mem_addr),       vec_w_t'(0));
        checkOutput("rst_mem_wdata",  vec_w_t'(mem_wdata),      vec_w_t'(0));

        alu_result  = 32'h5;
        valu_result = '1;
        select_alu  = 1'b0;
        #1 checkOutput("wb_scalar", wb_data, vec_w_t'(32'h5));
        select_alu  = 1'b1;
        #1 checkOutput("wb_vector", wb_data, {LANES*DATA_W{1'b1}});
        alu_result  = 32'hCAFE0001;
        valu_result = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        select_alu  = 1'b0;
        #1 checkOutput("wb_scalar_zext", wb_data, vec_w_t'(32'hCAFE0001));

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready", vec_w_t'(bus.req_ready), vec_w_t'(1));

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("v%0d", i), vecs[i]);
        end
        checkOutput("stride0_last_lane", vec_w_t'(mem[32'h300 >> 2]), vec_w_t'(32'hD4));

        // Second request held on req_valid while a vector load is busy.
        driveRequest(OP_VLD, 32'h200, 32'hFFFFFFF8, '0);
        busy_we   = 0;
        resp_cyc  = -1;
        ready_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_op     = OP_SST;
                bus.req_addr   = 32'h40;
                bus.req_stride = 32'h0;
                bus.req_wdata  = vec_w_t'(32'h77);
            end
            if (mem_we) busy_we++;
            if (bus.resp_valid) begin
                resp_cyc  = c;
                got_rdata = bus.resp_rdata;
            end
            if (bus.req_ready) begin
                ready_cyc = c;
                break;
            end
        end
        checkOutput("busy_resp_cycle",  vec_w_t'(resp_cyc),  vec_w_t'(6));
        checkOutput("busy_ready_cycle", vec_w_t'(ready_cyc), vec_w_t'(7));
        checkOutput("busy_no_writes",   vec_w_t'(busy_we),   vec_w_t'(0));
        checkOutput("busy_rdata",       got_rdata,           row3);
        if (ready_cyc < 0) bus.req_valid = 1'b0;
        @(posedge clk);
        collectResponse();
        checkOutput("second_latency", vec_w_t'(lat), vec_w_t'(2));
        checkOutput("second_nwrites", vec_w_t'(wr_addr.size()), vec_w_t'(1));
        if (wr_addr.size() > 0) begin
            checkOutput("second_waddr", vec_w_t'(wr_addr[0]), vec_w_t'(32'h40));
            checkOutput("second_wdata", vec_w_t'(wr_data[0]), vec_w_t'(32'h77));
        end
        checkOutput("second_rdata_kept", got_rdata, row3);
        @(negedge clk);

        // Reset during the third ISSUE cycle of a vector store.
        driveRequest(OP_VST, 32'h400, 32'h4, 128'h44444444_33333333_22222222_11111111);
        cnt_we = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (mem_we) cnt_we++;
            if (c == 3) reset = 1'b1;
        end
        checkOutput("abort_pre_writes", vec_w_t'(cnt_we), vec_w_t'(3));
        @(negedge clk);
        checkOutput("abort_mem_we",     vec_w_t'(mem_we),         vec_w_t'(0));
        checkOutput("abort_ready_rst",  vec_w_t'(bus.req_ready),  vec_w_t'(0));
        checkOutput("abort_resp_valid", vec_w_t'(bus.resp_valid), vec_w_t'(0));
        reset  = 1'b0;
        cnt_we = 0;
        cnt_rv = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("abort_ready_after", vec_w_t'(bus.req_ready), vec_w_t'(1));
            if (mem_we) cnt_we++;
            if (bus.resp_valid) cnt_rv++;
        end
        checkOutput("abort_no_writes", vec_w_t'(cnt_we), vec_w_t'(0));
        checkOutput("abort_no_resp",   vec_w_t'(cnt_rv), vec_w_t'(0));
        checkOutput("abort_rdata_clr", bus.resp_rdata,   vec_w_t'(0));
        checkOutput("abort_lane2_mem", vec_w_t'(mem[32'h408 >> 2]), vec_w_t'(32'h33333333));
        checkOutput("abort_lane3_mem", vec_w_t'(mem[32'h40C >> 2]), vec_w_t'(0));

        rec = '{OP_SLD, 32'h400, 32'h0, '0, 3, {96'h0, 32'h11111111}};
        applyStimulus("recover", rec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit");
    end
endmodule
